// File: rtl/wb_queue.sv
// Purpose : register-file writeback queue merging mem and ALU producers, with read-address hazard detection.
// Latency : request accepted at edge N drives wr_* in cycle N+1 and is written to the file at edge N+2.
// Backpress: ready from registered occupancy only; mem has priority for the last free slot; drain never stalls.
//
// Optional build macro: WB_FORWARD_EN adds o_rs_fwd_data / o_rt_fwd_data (youngest matching queued data).
//
// Ports:
//   i_clk, i_rst                  rising-edge clock, synchronous active-high reset
//   i_mem_valid/o_mem_ready       memory-unit writeback handshake, i_mem_rd / i_mem_data payload
//   i_alu_valid/o_alu_ready       ALU writeback handshake, i_alu_rd / i_alu_data payload
//   o_wr_en, o_wr_rd, o_wr_data   register-file write port, driven from the head entry
//   i_rs, i_rt                    decode read addresses
//   o_rs_busy, o_rt_busy          a queued write (head included) targets the read address
//   o_count                       number of valid entries
//   o_rs_fwd_data, o_rt_fwd_data  (WB_FORWARD_EN) youngest queued data for rs / rt, 0 when not busy
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_mem_valid,
    output logic          o_mem_ready,
    input  logic [4:0]    i_mem_rd,
    input  logic [31:0]   i_mem_data,
    input  logic          i_alu_valid,
    output logic          o_alu_ready,
    input  logic [4:0]    i_alu_rd,
    input  logic [31:0]   i_alu_data,
    output logic          o_wr_en,
    output logic [4:0]    o_wr_rd,
    output logic [31:0]   o_wr_data,
    input  logic [4:0]    i_rs,
    input  logic [4:0]    i_rt,
    output logic          o_rs_busy,
    output logic          o_rt_busy,
    output logic [AW:0]   o_count
`ifdef WB_FORWARD_EN
    ,
    output logic [31:0]   o_rs_fwd_data,
    output logic [31:0]   o_rt_fwd_data
`endif
);

    logic [4:0]    r_rd   [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic [AW:0]   w_free;
    logic          w_mem_ready;
    logic          w_alu_ready;
    logic          w_mem_push;
    logic          w_alu_push;
    logic          w_pop;
    logic [AW:0]   w_push_cnt;
    logic [AW-1:0] w_alu_slot;
    logic [AW-1:0] w_idx;
    logic          w_rs_hit;
    logic          w_rt_hit;
`ifdef WB_FORWARD_EN
    logic [31:0]   w_rs_fwd;
    logic [31:0]   w_rt_fwd;
`endif

    // Free space comes from the registered count only: a pop in this cycle
    // does not free a slot until the next cycle.
    assign w_free      = (AW+1)'(DEPTH) - r_count;
    assign w_mem_ready = (w_free != '0);
    // The ALU only gets the last free slot when the memory unit is not asking for it.
    assign w_alu_ready = (w_free >= (AW+1)'(2)) | ((w_free == (AW+1)'(1)) & ~i_mem_valid);

    // rd==0 requests complete the handshake but are never stored.
    assign w_mem_push  = i_mem_valid & w_mem_ready & (i_mem_rd != 5'd0);
    assign w_alu_push  = i_alu_valid & w_alu_ready & (i_alu_rd != 5'd0);
    assign w_pop       = (r_count != '0);
    assign w_push_cnt  = (AW+1)'(w_mem_push) + (AW+1)'(w_alu_push);
    // Mem entry takes the older slot when both push in the same cycle.
    assign w_alu_slot  = r_tail + AW'(w_mem_push);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_tail  <= r_tail + AW'(w_push_cnt);
            r_count <= r_count + w_push_cnt - (AW+1)'(w_pop);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by head/tail/count.
    always_ff @(posedge i_clk) begin
        if (w_mem_push) begin
            r_rd[r_tail]   <= i_mem_rd;
            r_data[r_tail] <= i_mem_data;
        end
        if (w_alu_push) begin
            r_rd[w_alu_slot]   <= i_alu_rd;
            r_data[w_alu_slot] <= i_alu_data;
        end
    end

    // Walk entries oldest to youngest so a later match overrides an earlier one,
    // leaving the youngest matching data in the forwarding result.
    always_comb begin
        w_idx    = r_head;
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
`ifdef WB_FORWARD_EN
        w_rs_fwd = '0;
        w_rt_fwd = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + AW'(k);
            if ((AW+1)'(k) < r_count) begin
                if ((i_rs != 5'd0) && (r_rd[w_idx] == i_rs)) begin
                    w_rs_hit = 1'b1;
`ifdef WB_FORWARD_EN
                    w_rs_fwd = r_data[w_idx];
`endif
                end
                if ((i_rt != 5'd0) && (r_rd[w_idx] == i_rt)) begin
                    w_rt_hit = 1'b1;
`ifdef WB_FORWARD_EN
                    w_rt_fwd = r_data[w_idx];
`endif
                end
            end
        end
    end

    assign o_mem_ready = w_mem_ready;
    assign o_alu_ready = w_alu_ready;
    assign o_wr_en     = w_pop;
    assign o_wr_rd     = r_rd[r_head];
    assign o_wr_data   = r_data[r_head];
    assign o_rs_busy   = w_rs_hit;
    assign o_rt_busy   = w_rt_hit;
    assign o_count     = r_count;
`ifdef WB_FORWARD_EN
    assign o_rs_fwd_data = w_rs_fwd;
    assign o_rt_fwd_data = w_rt_fwd;
`endif

endmodule
